// File: rtl/coll_pkg.sv
`default_nettype none
// ============================================================================
// coll_pkg : shared widths, object record, FSM encoding and r2 helper
// Rev 1.0
// ============================================================================
package coll_pkg;

   localparam int COORD_W = 16;
   localparam int RAD_W   = 8;
   localparam int CNT_W   = 8;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic [COORD_W-1:0] vx;
      logic [COORD_W-1:0] vy;
      logic [RAD_W-1:0]   r;
   } obj_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_ISSUE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_GAP   = 3'd4,
      ST_FIN   = 3'd5
   } state_t;

   // (ra+rb)^2 in full 18-bit precision, clamped to the 16-bit operand range
   function automatic logic [COORD_W-1:0] sat_r2(input logic [RAD_W-1:0] ra,
                                                 input logic [RAD_W-1:0] rb);
      logic [RAD_W:0]     sum;
      logic [2*RAD_W+1:0] sq;
      sum = {1'b0, ra} + {1'b0, rb};
      sq  = {{(RAD_W+1){1'b0}}, sum} * {{(RAD_W+1){1'b0}}, sum};
      if (|sq[2*RAD_W+1:COORD_W])
         return '1;
      return sq[COORD_W-1:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/coll_obj_table.sv
`default_nettype none
// ============================================================================
// coll_obj_table : N_OBJ-entry object register file, 1 write / 2 read ports
// Rev 1.0
// ============================================================================
module coll_obj_table
   import coll_pkg::*;
#(
   parameter int N_OBJ = 8
) (
   input  logic       clock,
   input  logic       wr_en,
   input  logic [3:0] wr_addr,
   input  obj_t       wr_obj,
   input  logic [3:0] rd_idx_a,
   input  logic [3:0] rd_idx_b,
   output obj_t       rd_obj_a,
   output obj_t       rd_obj_b
);

   obj_t mem [N_OBJ];

   // Addresses at or beyond N_OBJ match no entry and are dropped
   always_ff @(posedge clock) begin
      for (int k = 0; k < N_OBJ; k++) begin
         if (wr_en && (wr_addr == 4'(k)))
            mem[k] <= wr_obj;
      end
   end

   always_comb begin
      rd_obj_a = '0;
      rd_obj_b = '0;
      for (int k = 0; k < N_OBJ; k++) begin
         if (rd_idx_a == 4'(k))
            rd_obj_a = mem[k];
         if (rd_idx_b == 4'(k))
            rd_obj_b = mem[k];
      end
   end

endmodule
`default_nettype wire

// File: rtl/coll_pair_sched.sv
`default_nettype none
// ============================================================================
// coll_pair_sched : sweeps all object pairs (i<j) through the collision engine
// Rev 1.0
// ============================================================================
module coll_pair_sched
   import coll_pkg::*;
#(
   parameter int N_OBJ   = 8,
   parameter int TIMEOUT = 64
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [3:0]       wr_addr,
   input  logic [15:0]      wr_x,
   input  logic [15:0]      wr_y,
   input  logic [15:0]      wr_vx,
   input  logic [15:0]      wr_vy,
   input  logic [7:0]       wr_r,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             err_timeout,
   output logic [15:0]      x1,
   output logic [15:0]      y1,
   output logic [15:0]      x2,
   output logic [15:0]      y2,
   output logic [15:0]      vx1,
   output logic [15:0]      vy1,
   output logic [15:0]      vx2,
   output logic [15:0]      vy2,
   output logic [15:0]      r2,
   output logic             in_rdy,
   input  logic             out_rdy,
   input  logic             trial,
   output logic [7:0]       hit_cnt,
   output logic [N_OBJ-1:0] obj_hit
);

   localparam int               TMO_W    = $clog2(TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
   localparam logic [4:0]       N_LIM    = 5'(N_OBJ);
   localparam logic [4:0]       LAST_I   = 5'(N_OBJ - 1);

   state_t           state;
   state_t           state_nxt;
   logic [3:0]       idx_i;
   logic [3:0]       idx_j;
   logic [4:0]       j_inc;
   logic [4:0]       i_adv;
   logic [3:0]       j_adv;
   logic [TMO_W-1:0] tmo_cnt;
   logic             start_acc;
   logic             take_res;
   logic             tmo_fire;
   logic [N_OBJ-1:0] pair_mask;
   obj_t             obj_wr;
   obj_t             obj_i;
   obj_t             obj_j;

   always_comb begin
      obj_wr    = '0;
      obj_wr.x  = wr_x;
      obj_wr.y  = wr_y;
      obj_wr.vx = wr_vx;
      obj_wr.vy = wr_vy;
      obj_wr.r  = wr_r;
   end

   coll_obj_table #(
      .N_OBJ (N_OBJ)
   ) u_table (
      .clock    (clock),
      .wr_en    (wr_en && !busy),
      .wr_addr  (wr_addr),
      .wr_obj   (obj_wr),
      .rd_idx_a (idx_i),
      .rd_idx_b (idx_j),
      .rd_obj_a (obj_i),
      .rd_obj_b (obj_j)
   );

   // Lexicographic pair advance; j wraps to i+1 of the next row
   always_comb begin
      j_inc = {1'b0, idx_j} + 5'd1;
      if (j_inc == N_LIM) begin
         i_adv = {1'b0, idx_i} + 5'd1;
         j_adv = idx_i + 4'd2;
      end else begin
         i_adv = {1'b0, idx_i};
         j_adv = j_inc[3:0];
      end
   end

   always_comb begin
      pair_mask = '0;
      for (int k = 0; k < N_OBJ; k++) begin
         if ((idx_i == 4'(k)) || (idx_j == 4'(k)))
            pair_mask[k] = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start_acc = 1'b0;
      take_res  = 1'b0;
      tmo_fire  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               start_acc = 1'b1;
               state_nxt = ST_LOAD;
            end
         end
         ST_LOAD:  state_nxt = ST_ISSUE;
         ST_ISSUE: state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (out_rdy) begin
               take_res  = 1'b1;
               state_nxt = ST_GAP;
            end else if (tmo_cnt == TMO_LAST) begin
               tmo_fire  = 1'b1;
               state_nxt = ST_FIN;
            end
         end
         ST_GAP:   state_nxt = (i_adv == LAST_I) ? ST_FIN : ST_LOAD;
         ST_FIN:   state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Handshake/status outputs are registered from the next state so they
   // line up with the state they describe and clear asynchronously on reset
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         busy        <= 1'b0;
         done        <= 1'b0;
         in_rdy      <= 1'b0;
         err_timeout <= 1'b0;
         hit_cnt     <= '0;
         obj_hit     <= '0;
         idx_i       <= '0;
         idx_j       <= '0;
         tmo_cnt     <= '0;
         x1          <= '0;
         y1          <= '0;
         vx1         <= '0;
         vy1         <= '0;
         x2          <= '0;
         y2          <= '0;
         vx2         <= '0;
         vy2         <= '0;
         r2          <= '0;
      end else begin
         busy   <= (state_nxt != ST_IDLE);
         done   <= (state_nxt == ST_FIN);
         in_rdy <= (state_nxt == ST_ISSUE) || (state_nxt == ST_WAIT);

         if (start_acc) begin
            hit_cnt     <= '0;
            obj_hit     <= '0;
            err_timeout <= 1'b0;
            idx_i       <= 4'd0;
            idx_j       <= 4'd1;
         end

         if (state == ST_LOAD) begin
            x1  <= obj_i.x;
            y1  <= obj_i.y;
            vx1 <= obj_i.vx;
            vy1 <= obj_i.vy;
            x2  <= obj_j.x;
            y2  <= obj_j.y;
            vx2 <= obj_j.vx;
            vy2 <= obj_j.vy;
            r2  <= sat_r2(obj_i.r, obj_j.r);
         end

         if (state == ST_ISSUE)
            tmo_cnt <= '0;
         else if (state == ST_WAIT)
            tmo_cnt <= tmo_cnt + TMO_W'(1);

         if (take_res && trial) begin
            if (hit_cnt != 8'hFF)
               hit_cnt <= hit_cnt + 8'd1;
            obj_hit <= obj_hit | pair_mask;
         end

         if (tmo_fire)
            err_timeout <= 1'b1;

         if (state == ST_GAP) begin
            idx_i <= i_adv[3:0];
            idx_j <= j_adv;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_coll_pair_sched.sv
`default_nettype none
// ============================================================================
// tb_coll_pair_sched : directed bench with a negedge engine model, N_OBJ=4
// Rev 1.0
// ============================================================================
module tb_coll_pair_sched;

   localparam int N   = 4;
   localparam int TMO = 64;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        wr_en = 1'b0;
   logic [3:0]  wr_addr = '0;
   logic [15:0] wr_x = '0, wr_y = '0, wr_vx = '0, wr_vy = '0;
   logic [7:0]  wr_r = '0;
   logic        start = 1'b0;
   logic        busy, done, err_timeout, in_rdy;
   logic [15:0] x1, y1, x2, y2, vx1, vy1, vx2, vy2, r2;
   logic        out_rdy = 1'b0;
   logic        trial = 1'b0;
   logic [7:0]  hit_cnt;
   logic [N-1:0] obj_hit;

   int n_tests = 0;
   int n_fail  = 0;

   // engine controls (written by the main process only)
   int eng_mode = 1;
   int eng_lat  = 1;
   bit spur_en  = 1'b0;
   bit inj_rdy  = 1'b0;
   bit hit_tab [4][4];
   int sweep_id = 0;

   // engine state and logs (written by the engine process only)
   int lat_cnt = 0, seen_id = 0, done_cnt = 0, req_n = 0;
   bit answered = 1'b0, resp_prev = 1'b0, prev_in = 1'b0, real_resp;
   int low_run = 0, high_run = 0, min_gap = 1000, max_gap = 0, max_high = 0;
   logic [15:0] rx1 [16];
   logic [15:0] rx2 [16];
   logic [15:0] rr2 [16];
   logic [15:0] f_y1, f_vx1, f_vy1, f_y2, f_vx2, f_vy2;

   int ei [6] = '{0, 0, 0, 1, 1, 2};
   int ej [6] = '{1, 2, 3, 2, 3, 3};
   int d0;

   coll_pair_sched #(.N_OBJ(N), .TIMEOUT(TMO)) dut (
      .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_x(wr_x), .wr_y(wr_y), .wr_vx(wr_vx), .wr_vy(wr_vy), .wr_r(wr_r),
      .start(start), .busy(busy), .done(done), .err_timeout(err_timeout),
      .x1(x1), .y1(y1), .x2(x2), .y2(y2), .vx1(vx1), .vy1(vy1),
      .vx2(vx2), .vy2(vy2), .r2(r2), .in_rdy(in_rdy), .out_rdy(out_rdy),
      .trial(trial), .hit_cnt(hit_cnt), .obj_hit(obj_hit)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Engine model: answers LAT cycles after a request first appears
   always @(negedge clock) begin
      out_rdy   = 1'b0;
      trial     = 1'b0;
      real_resp = 1'b0;
      if (done)
         done_cnt++;
      if (seen_id != sweep_id) begin
         seen_id  = sweep_id;
         req_n    = 0;
         min_gap  = 1000;
         max_gap  = 0;
         max_high = 0;
         low_run  = 0;
      end
      if (reset) begin
         lat_cnt   = 0;
         answered  = 1'b0;
         resp_prev = 1'b0;
         prev_in   = 1'b0;
         low_run   = 0;
         high_run  = 0;
      end else begin
         if (in_rdy) begin
            if (!prev_in) begin
               if (req_n > 0) begin
                  if (low_run < min_gap) min_gap = low_run;
                  if (low_run > max_gap) max_gap = low_run;
               end
               high_run = 0;
            end
            high_run++;
            if (high_run > max_high) max_high = high_run;
            low_run = 0;
         end else if (busy) begin
            low_run++;
         end
         prev_in = in_rdy;

         if (in_rdy && !answered) begin
            if (lat_cnt == 0 && req_n < 16) begin
               if (req_n == 0) begin
                  f_y1 = y1; f_vx1 = vx1; f_vy1 = vy1;
                  f_y2 = y2; f_vx2 = vx2; f_vy2 = vy2;
               end
               rx1[req_n] = x1;
               rx2[req_n] = x2;
               rr2[req_n] = r2;
               req_n++;
            end
            if (eng_mode == 1 && lat_cnt == eng_lat) begin
               out_rdy   = 1'b1;
               trial     = hit_tab[x1[1:0]][x2[1:0]];
               answered  = 1'b1;
               real_resp = 1'b1;
            end else begin
               lat_cnt++;
            end
         end else if (!in_rdy) begin
            if (spur_en && resp_prev) begin
               out_rdy = 1'b1;
               trial   = 1'b1;
            end
            answered = 1'b0;
            lat_cnt  = 0;
         end
         resp_prev = real_resp;
         if (inj_rdy) begin
            out_rdy = 1'b1;
            trial   = 1'b1;
         end
      end
   end

   task automatic write_obj(input int a, input logic [15:0] x, input logic [7:0] r);
      @(posedge clock); #1;
      wr_en = 1'b1; wr_addr = 4'(a); wr_x = x;
      wr_y = 16'h0100 + x; wr_vx = 16'h0200 + x; wr_vy = 16'hFFFF - x; wr_r = r;
      @(posedge clock); #1;
      wr_en = 1'b0;
   endtask

   task automatic start_sweep(input bit inj);
      @(posedge clock); #1;
      sweep_id++; start = 1'b1; inj_rdy = inj;
      @(posedge clock); #1;
      start = 1'b0; inj_rdy = 1'b0;
      @(negedge clock);
      check("busy_after_start", busy, 1);
   endtask

   task automatic wait_sweep();
      int c;
      c = 0;
      while (!(done_cnt != d0 && !busy) && c < 3000) begin
         @(negedge clock);
         c++;
      end
      check("sweep_finished", (done_cnt != d0 && !busy), 1);
      repeat (2) @(negedge clock);
   endtask

   task automatic check_order(input string tag);
      check({tag, "_nreq"}, req_n, 6);
      for (int p = 0; p < 6; p++) begin
         check({tag, "_x1"}, rx1[p], ei[p]);
         check({tag, "_x2"}, rx2[p], ej[p]);
      end
   endtask

   initial begin
      int c;
      logic [15:0] exp_r2 [6];
      exp_r2 = '{16'hFFFF, 16'd41209, 16'd41616, 16'd41209, 16'd41616, 16'd49};
      for (int a = 0; a < 4; a++)
         for (int b = 0; b < 4; b++)
            hit_tab[a][b] = 1'b0;

      // reset state
      repeat (3) @(negedge clock);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err_timeout, 0);
      check("rst_in_rdy", in_rdy, 0);
      check("rst_x1", x1, 0);
      check("rst_vy2", vy2, 0);
      check("rst_r2", r2, 0);
      check("rst_hit_cnt", hit_cnt, 0);
      check("rst_obj_hit", obj_hit, 0);
      @(posedge clock); #1;
      reset = 1'b0;

      for (int k = 0; k < N; k++)
         write_obj(k, 16'(k), 8'd2);
      write_obj(4, 16'd77, 8'd9);

      // basic sweep; out_rdy injected together with start in IDLE
      hit_tab[0][2] = 1'b1;
      d0 = done_cnt;
      start_sweep(1'b1);
      wait_sweep();
      check_order("sweep1");
      for (int p = 0; p < 6; p++)
         check("sweep1_r2", rr2[p], 16'd16);
      check("sweep1_y1", f_y1, 16'h0100);
      check("sweep1_vx1", f_vx1, 16'h0200);
      check("sweep1_vy1", f_vy1, 16'hFFFF);
      check("sweep1_y2", f_y2, 16'h0101);
      check("sweep1_vx2", f_vx2, 16'h0201);
      check("sweep1_vy2", f_vy2, 16'hFFFE);
      check("sweep1_hit_cnt", hit_cnt, 1);
      check("sweep1_obj_hit", obj_hit, 4'b0101);
      check("sweep1_done_cnt", done_cnt - d0, 1);
      check("sweep1_err", err_timeout, 0);
      check("sweep1_min_gap", min_gap, 2);
      check("sweep1_max_gap", max_gap, 2);

      // spurious out_rdy in GAP must not count
      hit_tab[0][2] = 1'b0;
      hit_tab[1][3] = 1'b1;
      spur_en = 1'b1;
      d0 = done_cnt;
      start_sweep(1'b0);
      wait_sweep();
      spur_en = 1'b0;
      check_order("spur");
      check("spur_hit_cnt", hit_cnt, 1);
      check("spur_obj_hit", obj_hit, 4'b1010);
      check("spur_min_gap", min_gap, 2);
      check("spur_max_gap", max_gap, 2);

      // r2 saturation and small sums
      write_obj(0, 16'd0, 8'd200);
      write_obj(1, 16'd1, 8'd200);
      write_obj(2, 16'd2, 8'd3);
      write_obj(3, 16'd3, 8'd4);
      d0 = done_cnt;
      start_sweep(1'b0);
      wait_sweep();
      for (int p = 0; p < 6; p++)
         check("radii_r2", rr2[p], exp_r2[p]);

      // start and table write while busy are ignored
      d0 = done_cnt;
      start_sweep(1'b0);
      c = 0;
      while (req_n < 2 && c < 200) begin
         @(negedge clock);
         c++;
      end
      check("busy_reach2", req_n >= 2, 1);
      @(posedge clock); #1;
      start = 1'b1; wr_en = 1'b1; wr_addr = 4'd3; wr_x = 16'd99; wr_r = 8'd1;
      @(posedge clock); #1;
      start = 1'b0; wr_en = 1'b0;
      wait_sweep();
      check_order("busy");
      check("busy_r2_last", rr2[5], 16'd49);
      check("busy_done_cnt", done_cnt - d0, 1);
      check("busy_hit_cnt", hit_cnt, 1);

      // engine never answers
      eng_mode = 0;
      d0 = done_cnt;
      start_sweep(1'b0);
      wait_sweep();
      eng_mode = 1;
      check("tmo_err", err_timeout, 1);
      check("tmo_done_cnt", done_cnt - d0, 1);
      check("tmo_hit_cnt", hit_cnt, 0);
      check("tmo_obj_hit", obj_hit, 0);
      check("tmo_nreq", req_n, 1);
      check("tmo_in_rdy_high", max_high, TMO + 1);

      // reset in WAIT of the third pair, then a full rerun
      eng_lat = 5;
      d0 = done_cnt;
      start_sweep(1'b0);
      check("tmo_err_cleared", err_timeout, 0);
      c = 0;
      while (req_n < 3 && c < 200) begin
         @(negedge clock);
         c++;
      end
      check("rst_reach3", req_n, 3);
      @(negedge clock);
      @(negedge clock);
      check("rst_pre_in_rdy", in_rdy, 1);
      #1 reset = 1'b1;
      #1;
      check("rst_mid_in_rdy", in_rdy, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_hit_cnt", hit_cnt, 0);
      @(negedge clock);
      @(posedge clock); #1;
      reset = 1'b0;
      eng_lat = 1;
      check("rst_no_done", done_cnt - d0, 0);
      d0 = done_cnt;
      start_sweep(1'b0);
      wait_sweep();
      check_order("rerun");
      check("rerun_done_cnt", done_cnt - d0, 1);
      check("rerun_hit_cnt", hit_cnt, 1);
      check("rerun_obj_hit", obj_hit, 4'b1010);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
